// File: rtl/mem_port_arbiter_if.sv
// Request/response port bundle shared by the core and debug requesters.
//   req_valid/req_ready  : request handshake (accepted on valid & ready)
//   req_we               : 1 = write, 0 = read
//   req_addr             : byte address
//   req_wdata/req_wstrb  : write data and byte enables (writes only)
//   resp_valid           : one-cycle response pulse
//   resp_rdata           : read data, 0 for writes and errors
//   resp_err             : misaligned/out-of-range, qualified by resp_valid
// master = requester side, slave = arbiter side.
interface mem_port_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one word memory between the core port (c)
// and the debug/loader port (d). One transaction in flight, one-cycle
// synchronous read; misaligned or out-of-range requests complete with an
// error response and no memory access.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   c, d       : request/response ports (slave side of mem_port_arbiter_if)
//   mem_en     : memory access strobe
//   mem_wstrb  : byte write enables, 0 for reads
//   mem_addr   : word index (addr[31:2])
//   mem_wdata  : write data
//   mem_rdata  : read data, valid the cycle after mem_en
//   owner      : 0 = core, 1 = debug; holder of the current or last grant
module mem_port_arbiter #(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  mem_port_arbiter_if.slave            c,
  mem_port_arbiter_if.slave            d,
  output logic                         mem_en,
  output logic [3:0]                   mem_wstrb,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata,
  output logic                         owner
);
  localparam int unsigned AW         = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;      // response carries memory read data

  logic        win;             // 0 = core, 1 = debug
  logic        accept;
  logic        legal;
  logic        resp_fire;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [31:0] rdata;

  // With a single requester, ~c.req_valid picks whichever one is valid.
  always_comb begin
    if (c.req_valid && d.req_valid) begin
      win = FIXED_PRIORITY ? 1'b0 : ~owner_q;
    end else begin
      win = ~c.req_valid;
    end
  end

  always_comb begin
    sel_we    = win ? d.req_we    : c.req_we;
    sel_addr  = win ? d.req_addr  : c.req_addr;
    sel_wdata = win ? d.req_wdata : c.req_wdata;
    sel_wstrb = win ? d.req_wstrb : c.req_wstrb;
  end

  assign legal  = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < ADDR_LIMIT);
  assign accept = reset && (state_q == S_IDLE) && (c.req_valid || d.req_valid);

  assign c.req_ready = accept & ~win;
  assign d.req_ready = accept &  win;

  assign mem_en    = accept & legal;
  assign mem_wstrb = (mem_en && sel_we) ? sel_wstrb : '0;
  assign mem_addr  = sel_addr[AW+1:2];
  assign mem_wdata = sel_wdata;

  // Reset low in the RESP cycle suppresses the pending response.
  assign resp_fire = reset && (state_q == S_RESP);
  assign rdata     = rd_q ? mem_rdata : '0;

  assign c.resp_valid = resp_fire & ~owner_q;
  assign d.resp_valid = resp_fire &  owner_q;
  assign c.resp_rdata = c.resp_valid ? rdata : '0;
  assign d.resp_rdata = d.resp_valid ? rdata : '0;
  assign c.resp_err   = c.resp_valid & err_q;
  assign d.resp_err   = d.resp_valid & err_q;

  assign owner = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RESP;
          owner_d = win;
          err_d   = ~legal;
          rd_d    = legal & ~sel_we;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b1;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned MW = 1024;
  localparam int unsigned AW = $clog2(MW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          rst2;
  logic          mem_en, mem_en2;
  logic [3:0]    mem_wstrb, mem_wstrb2;
  logic [AW-1:0] mem_addr, mem_addr2;
  logic [31:0]   mem_wdata, mem_wdata2;
  logic [31:0]   mem_rdata;
  logic [31:0]   mem_rdata2;
  logic          owner, owner2;

  mem_port_arbiter_if cif ();
  mem_port_arbiter_if dif ();
  mem_port_arbiter_if c2if ();
  mem_port_arbiter_if d2if ();

  mem_port_arbiter #(.MEM_WORDS(MW), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset), .c(cif), .d(dif),
    .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_port_arbiter #(.MEM_WORDS(MW), .FIXED_PRIORITY(1'b1)) dut_fixed (
    .clk(clk), .reset(rst2), .c(c2if), .d(d2if),
    .mem_en(mem_en2), .mem_wstrb(mem_wstrb2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .owner(owner2)
  );
  assign mem_rdata2 = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  bit done2    = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    merge = old;
    for (int b = 0; b < 4; b++) if (st[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  // Memory behind the DUT, and an independent golden copy for the model.
  logic [31:0] mem  [MW];
  logic [31:0] gold [MW];

  always @(posedge clk) begin
    if (mem_en) begin
      mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_wstrb);
      mem_rdata     <= mem[mem_addr];
    end
  end

  // Transaction-level reference model: at most one pending response.
  bit          init_m = 1'b0;
  bit          owner_m;
  bit          pend_m = 1'b0;
  bit          pend_port;
  bit          pend_err;
  logic [31:0] pend_data;
  bit          acc_c = 1'b0;
  bit          acc_d = 1'b0;

  initial begin : compare
    bit          w, any, legal;
    logic        we;
    logic [31:0] a, wd;
    logic [3:0]  st;
    int unsigned idx;
    forever begin
      @(negedge clk);
      if (done) break;
      acc_c = 1'b0;
      acc_d = 1'b0;
      if (!reset) begin
        chk1("rst_c_ready", cif.req_ready, 1'b0);
        chk1("rst_d_ready", dif.req_ready, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_c_resp_valid", cif.resp_valid, 1'b0);
        chk1("rst_d_resp_valid", dif.resp_valid, 1'b0);
        pend_m  = 1'b0;
        owner_m = 1'b1;
        init_m  = 1'b1;
      end else if (init_m) begin
        chk1("owner", owner, owner_m);
        if (pend_m) begin
          chk1("c_resp_valid", cif.resp_valid, pend_port == 1'b0);
          chk1("d_resp_valid", dif.resp_valid, pend_port == 1'b1);
          chk1("resp_c_ready", cif.req_ready, 1'b0);
          chk1("resp_d_ready", dif.req_ready, 1'b0);
          chk1("resp_mem_en", mem_en, 1'b0);
          if (!pend_port) begin
            chk32("c_resp_rdata", cif.resp_rdata, pend_data);
            chk1("c_resp_err", cif.resp_err, pend_err);
          end else begin
            chk32("d_resp_rdata", dif.resp_rdata, pend_data);
            chk1("d_resp_err", dif.resp_err, pend_err);
          end
          pend_m = 1'b0;
        end else begin
          chk1("idle_c_resp_valid", cif.resp_valid, 1'b0);
          chk1("idle_d_resp_valid", dif.resp_valid, 1'b0);
          any = cif.req_valid || dif.req_valid;
          if (cif.req_valid && dif.req_valid) w = !owner_m;
          else w = dif.req_valid;
          chk1("c_req_ready", cif.req_ready, any && !w);
          chk1("d_req_ready", dif.req_ready, any && w);
          if (any) begin
            we    = w ? dif.req_we    : cif.req_we;
            a     = w ? dif.req_addr  : cif.req_addr;
            wd    = w ? dif.req_wdata : cif.req_wdata;
            st    = w ? dif.req_wstrb : cif.req_wstrb;
            legal = (a % 4 == 0) && (a < 4 * MW);
            chk1("mem_en", mem_en, legal);
            pend_data = 32'h0;
            if (legal) begin
              idx = a / 4;
              chk32("mem_addr", 32'(mem_addr), idx);
              chk32("mem_wstrb", {28'h0, mem_wstrb}, we ? {28'h0, st} : 32'h0);
              if (we) begin
                chk32("mem_wdata", mem_wdata, wd);
                gold[idx] = merge(gold[idx], wd, st);
              end else begin
                pend_data = gold[idx];
              end
            end
            pend_m    = 1'b1;
            pend_port = w;
            pend_err  = !legal;
            owner_m   = w;
            acc_c     = !w;
            acc_d     = w;
          end else begin
            chk1("idle_mem_en", mem_en, 1'b0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] st);
    if (!port) begin
      cif.req_valid = v; cif.req_we = we; cif.req_addr = addr;
      cif.req_wdata = wdata; cif.req_wstrb = st;
    end else begin
      dif.req_valid = v; dif.req_we = we; dif.req_addr = addr;
      dif.req_wdata = wdata; dif.req_wstrb = st;
    end
  endtask

  // Present a request, wait (bounded) for acceptance, then drop valid.
  // Returns at the start of the response cycle.
  task automatic req(input bit port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] st);
    bit got = 1'b0;
    set_req(port, 1'b1, we, addr, wdata, st);
    for (int k = 0; k < 20; k++) begin
      step();
      if (port ? acc_d : acc_c) begin
        got = 1'b1;
        break;
      end
    end
    chk1("req_accepted_in_time", got, 1'b1);
    if (!port) cif.req_valid = 1'b0;
    else dif.req_valid = 1'b0;
  endtask

  task automatic gen(output logic we, output logic [31:0] addr, output logic [31:0] wdata,
                     output logic [3:0] st);
    int unsigned r;
    r     = $urandom_range(0, 9);
    we    = 1'($urandom_range(0, 1));
    wdata = $urandom;
    st    = 4'($urandom);
    if (r == 0)      addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 1) addr = (4 * MW) + (32'($urandom_range(0, 1000)) << 2);
    else if (r == 2) addr = $urandom | 32'h8000_0000;
    else             addr = 32'($urandom_range(0, 63)) << 2;
  endtask

  // Fixed-priority instance: both requesters valid from reset, core wins every time.
  initial begin : fixed_prio
    rst2 = 1'b0;
    c2if.req_valid = 1'b1; c2if.req_we = 1'b0; c2if.req_addr = 32'h0;
    c2if.req_wdata = 32'h0; c2if.req_wstrb = 4'h0;
    d2if.req_valid = 1'b1; d2if.req_we = 1'b0; d2if.req_addr = 32'h4;
    d2if.req_wdata = 32'h0; d2if.req_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("fixed_c_ready", c2if.req_ready, (k % 2) == 0);
      chk1("fixed_d_ready", d2if.req_ready, 1'b0);
      chk1("fixed_c_resp_valid", c2if.resp_valid, (k % 2) == 1);
      chk1("fixed_d_resp_valid", d2if.resp_valid, 1'b0);
    end
    done2 = 1'b1;
  end

  initial begin : main
    logic        we;
    logic [31:0] a, wd;
    logic [3:0]  st;
    bit          c_has, d_has;

    for (int i = 0; i < int'(MW); i++) begin
      mem[i]  = $urandom;
      gold[i] = mem[i];
    end
    mem[42]  = 32'hdeadbeef;
    gold[42] = 32'hdeadbeef;
    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) step();
    chk1("reset_owner", owner, 1'b1);

    // Round-robin with both valid continuously from reset: c, d, c, d.
    reset = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("rr_c_ready", cif.req_ready, (k == 0) || (k == 4));
      chk1("rr_d_ready", dif.req_ready, (k == 2) || (k == 6));
    end
    step();
    cif.req_valid = 1'b0;
    dif.req_valid = 1'b0;
    step();

    // Core read of word 42.
    req(1'b0, 1'b0, 32'ha8, 32'h0, 4'h0);
    @(negedge clk);
    chk1("rd42_c_resp_valid", cif.resp_valid, 1'b1);
    chk32("rd42_c_resp_rdata", cif.resp_rdata, 32'hdeadbeef);
    chk1("rd42_c_resp_err", cif.resp_err, 1'b0);
    chk1("rd42_d_resp_valid", dif.resp_valid, 1'b0);
    step();

    // Debug write, then core read back.
    req(1'b1, 1'b1, 32'h0, 32'hcafebabe, 4'hf);
    step();
    req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk32("wr_rd_c_resp_rdata", cif.resp_rdata, 32'hcafebabe);
    step();

    // Misaligned and out-of-range reads.
    req(1'b0, 1'b0, 32'ha9, 32'h0, 4'h0);
    @(negedge clk);
    chk1("misalign_err", cif.resp_err, 1'b1);
    chk32("misalign_rdata", cif.resp_rdata, 32'h0);
    step();
    req(1'b0, 1'b0, 4 * MW, 32'h0, 4'h0);
    @(negedge clk);
    chk1("oor_err", cif.resp_err, 1'b1);
    chk32("oor_rdata", cif.resp_rdata, 32'h0);
    step();

    // Reset during the response cycle of a read, then a tie.
    req(1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_mid_no_resp", cif.resp_valid, 1'b0);
    step();
    reset = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 32'hc, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk1("post_rst_tie_c_ready", cif.req_ready, 1'b1);
    chk1("post_rst_tie_d_ready", dif.req_ready, 1'b0);
    step();
    chk1("post_rst_owner", owner, 1'b0);
    cif.req_valid = 1'b0;
    step();
    // Debug request held through the core transaction; accepted now.
    @(negedge clk);
    chk1("held_d_ready", dif.req_ready, 1'b1);
    step();
    dif.req_valid = 1'b0;
    step();

    // Randomized traffic with occasional resets.
    c_has = 1'b0;
    d_has = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (acc_c) c_has = 1'b0;
      if (acc_d) d_has = 1'b0;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      if (!c_has && ($urandom_range(0, 1) == 1)) begin
        gen(we, a, wd, st);
        set_req(1'b0, 1'b1, we, a, wd, st);
        c_has = 1'b1;
      end
      if (!d_has && ($urandom_range(0, 1) == 1)) begin
        gen(we, a, wd, st);
        set_req(1'b1, 1'b1, we, a, wd, st);
        d_has = 1'b1;
      end
      cif.req_valid = c_has;
      dif.req_valid = d_has;
      step();
    end
    cif.req_valid = 1'b0;
    dif.req_valid = 1'b0;
    repeat (3) step();

    chk1("fixed_prio_done", done2, 1'b1);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
